// File: rtl/click_demux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : click_demux_sel_ctrl
// Description : Credit-gated weighted round-robin / fixed scheduler driving the
//               2-phase sel channel of a two-way click demux. Optional token
//               statistics via macro CLICK_SEL_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module click_demux_sel_ctrl #(
    parameter int WW             = 4,
    parameter int CW             = 4,
    parameter int CREDIT_INIT    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int PHASE_INIT_SEL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [WW-1:0] weight_b,
    input  logic [WW-1:0] weight_c,
    input  logic          credit_b_ret,
    input  logic          credit_c_ret,
    output logic          sel_req,
    output logic          sel_data,
    input  logic          sel_ack,
    output logic          busy,
`ifdef CLICK_SEL_CTRL_STATS_EN
    output logic [15:0]   tokens_b,
    output logic [15:0]   tokens_c,
`endif
    output logic [CW-1:0] credits_b,
    output logic [CW-1:0] credits_c
);

    localparam logic [1:0]    S_IDLE        = 2'd0;
    localparam logic [1:0]    S_ISSUE       = 2'd1;
    localparam logic [1:0]    S_WAIT_ACK    = 2'd2;
    localparam logic          c_PHASE_INIT  = (PHASE_INIT_SEL != 0);
    localparam logic [CW-1:0] c_CREDIT_INIT = CW'(CREDIT_INIT);
    localparam logic [CW-1:0] c_CREDIT_MAX  = {CW{1'b1}};

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   r_sel_req;
    logic                   r_sel_data;
    logic [CW-1:0]          r_credits_b;
    logic [CW-1:0]          r_credits_c;
    logic                   r_ptr_b;
    logic [WW-1:0]          r_run;

    logic                   w_rr;
    logic                   w_elig_b;
    logic                   w_elig_c;
    logic                   w_pick_b;
    logic                   w_issue;
    logic                   w_ack_done;
    logic [WW-1:0]          w_weight_pick;
    logic [WW-1:0]          w_run_inc;
    logic                   w_run_done;

    function automatic logic [CW-1:0] f_credit_nxt(input logic [CW-1:0] cur,
                                                   input logic ret,
                                                   input logic take);
        logic [CW-1:0] nxt;
        nxt = cur;
        if (ret && !take && cur != c_CREDIT_MAX)
            nxt = cur + CW'(1);
        else if (take && !ret)
            nxt = cur - CW'(1);
        return nxt;
    endfunction

    // sel_ack is asynchronous; only the last sync stage is ever used
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ack_sync <= {SYNC_STAGES{c_PHASE_INIT}};
        else
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], sel_ack};
    end

    assign w_rr     = (mode == 2'd0) || (mode == 2'd3);
    assign w_elig_b = ((w_rr && weight_b != '0) || mode == 2'd1) && (r_credits_b != '0);
    assign w_elig_c = ((w_rr && weight_c != '0) || mode == 2'd2) && (r_credits_c != '0);
    assign w_pick_b = w_rr ? (r_ptr_b ? w_elig_b : !w_elig_c) : w_elig_b;
    assign w_issue  = (r_state == S_IDLE) && enable && (w_elig_b || w_elig_c);
    assign w_ack_done = (r_state == S_WAIT_ACK) && (w_ack_s == r_sel_req);

    // Switching to the other destination restarts its run from zero
    assign w_weight_pick = w_pick_b ? weight_b : weight_c;
    assign w_run_inc     = ((w_pick_b == r_ptr_b) ? r_run : '0) + WW'(1);
    assign w_run_done    = (w_run_inc >= w_weight_pick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_issue)    w_state_nxt = S_ISSUE;
            S_ISSUE:                    w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (w_ack_done) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        sel_req   = r_sel_req;
        sel_data  = r_sel_data;
        credits_b = r_credits_b;
        credits_c = r_credits_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_req   <= c_PHASE_INIT;
            r_sel_data  <= 1'b0;
            r_credits_b <= c_CREDIT_INIT;
            r_credits_c <= c_CREDIT_INIT;
            r_ptr_b     <= 1'b1;
            r_run       <= '0;
        end else begin
            r_credits_b <= f_credit_nxt(r_credits_b, credit_b_ret, w_issue && w_pick_b);
            r_credits_c <= f_credit_nxt(r_credits_c, credit_c_ret, w_issue && !w_pick_b);
            if (r_state == S_ISSUE)
                r_sel_req <= ~r_sel_req;
            if (w_issue) begin
                r_sel_data <= w_pick_b;
                if (w_rr) begin
                    r_ptr_b <= w_run_done ? !w_pick_b : w_pick_b;
                    r_run   <= w_run_done ? '0 : w_run_inc;
                end
            end
        end
    end

`ifdef CLICK_SEL_CTRL_STATS_EN
    logic [15:0] r_tokens_b;
    logic [15:0] r_tokens_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tokens_b <= '0;
            r_tokens_c <= '0;
        end else if (w_ack_done) begin
            if (r_sel_data)
                r_tokens_b <= r_tokens_b + 16'd1;
            else
                r_tokens_c <= r_tokens_c + 16'd1;
        end
    end

    assign tokens_b = r_tokens_b;
    assign tokens_c = r_tokens_c;
`endif

endmodule
`default_nettype wire

// File: tb/tb_click_demux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_click_demux_sel_ctrl
// Description : Directed scoreboard bench for click_demux_sel_ctrl with a
//               looped-back demux ack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_click_demux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] weight_b = 4'd1;
    logic [3:0] weight_c = 4'd1;
    logic       credit_b_ret = 1'b0;
    logic       credit_c_ret = 1'b0;
    logic       sel_req;
    logic       sel_data;
    logic       sel_ack = 1'b0;
    logic       busy;
    logic [3:0] credits_b;
    logic [3:0] credits_c;
`ifdef CLICK_SEL_CTRL_STATS_EN
    logic [15:0] tokens_b;
    logic [15:0] tokens_c;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_tok    = 0;
    int   base;
    logic ack_en   = 1'b1;
    logic prev_req = 1'b0;
    logic exp_q[$];

    click_demux_sel_ctrl #(
        .WW(4), .CW(4), .CREDIT_INIT(4), .SYNC_STAGES(2), .PHASE_INIT_SEL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .weight_b(weight_b), .weight_c(weight_c),
        .credit_b_ret(credit_b_ret), .credit_c_ret(credit_c_ret),
        .sel_req(sel_req), .sel_data(sel_data), .sel_ack(sel_ack), .busy(busy),
`ifdef CLICK_SEL_CTRL_STATS_EN
        .tokens_b(tokens_b), .tokens_c(tokens_c),
`endif
        .credits_b(credits_b), .credits_c(credits_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Token monitor and demux model: every req edge pops one expected route bit
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = sel_req;
            sel_ack  = 1'b0;
        end else begin
            if (sel_req !== prev_req) begin
                prev_req = sel_req;
                n_tok++;
                check("token_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    check("sel_data", sel_data, exp_q.pop_front());
            end
            if (ack_en)
                sel_ack = sel_req;
        end
    end

    task automatic wait_tokens(input int target);
        for (int i = 0; i < 200 && n_tok < target; i++) begin
            @(posedge clk);
            #2;
        end
        check("token_count", n_tok, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) begin
            @(posedge clk);
            #2;
        end
        repeat (6) @(posedge clk);
        #2;
        check("idle", busy, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_sel_req", sel_req, 0);
        check("rst_sel_data", sel_data, 0);
        check("rst_busy", busy, 0);
        check("rst_credits_b", credits_b, 4);
        check("rst_credits_c", credits_c, 4);

        // Fixed B drains exactly four credits
        mode = 2'd1;
        repeat (4) exp_q.push_back(1'b1);
        enable = 1'b1;
        wait_tokens(4);
        wait_idle();
        check("fixb_tokens", n_tok, 4);
        check("fixb_credits_b", credits_b, 0);
        check("fixb_credits_c", credits_c, 4);
        enable = 1'b0;

        // Weighted RR 2:1 -> 1,1,0,1,1,0
        do_reset();
        mode = 2'd0; weight_b = 4'd2; weight_c = 4'd1;
        base = n_tok;
        exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        enable = 1'b1;
        wait_tokens(base + 6);
        enable = 1'b0;
        wait_idle();
        check("rr_credits_b", credits_b, 0);
        check("rr_credits_c", credits_c, 2);

        // B starved: only C issues, then one B credit gives exactly one B token
        base = n_tok;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        enable = 1'b1;
        wait_tokens(base + 2);
        wait_idle();
        check("starve_tokens", n_tok, base + 2);
        exp_q.push_back(1'b1);
        @(posedge clk); #1 credit_b_ret = 1'b1;
        @(posedge clk); #1 credit_b_ret = 1'b0;
        wait_tokens(base + 3);
        wait_idle();
        check("starve_b_once", n_tok, base + 3);
        check("starve_credits_b", credits_b, 0);
        check("starve_credits_c", credits_c, 0);
        enable = 1'b0;

        // Simultaneous return and issue on C, then saturation
        do_reset();
        mode = 2'd2;
        base = n_tok;
        exp_q.push_back(1'b0);
        enable = 1'b1;
        wait_tokens(base + 1);
        enable = 1'b0;
        wait_idle();
        check("c_credit_3", credits_c, 3);
        exp_q.push_back(1'b0);
        @(posedge clk); #1 enable = 1'b1; credit_c_ret = 1'b1;
        @(posedge clk); #1 enable = 1'b0; credit_c_ret = 1'b0;
        check("c_net_zero", credits_c, 3);
        check("c_net_busy", busy, 1);
        wait_tokens(base + 2);
        wait_idle();
        credit_c_ret = 1'b1;
        repeat (12) @(posedge clk);
        #1 check("c_fill_15", credits_c, 15);
        @(posedge clk);
        #1 credit_c_ret = 1'b0;
        check("c_sat_15", credits_c, 15);

        // Reset while waiting for ack
        ack_en = 1'b0;
        mode = 2'd1;
        base = n_tok;
        exp_q.push_back(1'b1);
        enable = 1'b1;
        wait_tokens(base + 1);
        @(posedge clk); #1;
        check("wait_busy", busy, 1);
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_sel_req", sel_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_credits_b", credits_b, 4);
        check("midrst_credits_c", credits_c, 4);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_en = 1'b1;
        base = n_tok;
        exp_q.push_back(1'b1);
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 check("lat_pre_edge", sel_req, 0);
        @(posedge clk); #1 check("lat_edge_2cyc", sel_req, 1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        wait_tokens(base + 3);
        enable = 1'b0;
        wait_idle();
        mode = 2'd2;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        enable = 1'b1;
        wait_tokens(base + 5);
        enable = 1'b0;
        wait_idle();
        check("final_credits_b", credits_b, 1);
        check("final_credits_c", credits_c, 2);
`ifdef CLICK_SEL_CTRL_STATS_EN
        check("stats_tokens_b", tokens_b, 3);
        check("stats_tokens_c", tokens_c, 2);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
